snoop_stream_arbiter: RTL and testbench
=======================================

# snoop_stream_arbiter

Packet-level round-robin arbiter that merges the per-channel snoop streams (AR, R, AW, W) produced by the AXI-to-stream capture units onto the single `stream_*` AXI-Stream master of the read/write manager. A grant is locked for a whole packet (`src_tlast` to `src_tlast`), so beats from different channels never interleave. A per-source enable lets software gate channels. A one-deep output register decouples the sources from `stream_tready`.

## Interface
- `DATA_WIDTH`, 128: stream data width.
- `ID_WIDTH`, 32: tid width.
- `USER_WIDTH`, 64: tuser width; must be ≥ 16.
- `DEST_WIDTH`, 32: tdest width; must be ≥ clog2(NUM_SRC).
- `NUM_SRC`, 4: requesters. Index 0 = AR, 1 = R, 2 = AW, 3 = W.
- `MAX_BEATS`, 256: packet length limit in beats. Range 2..65535.

Ports:
- `clk`  in  1: the only clock.
- `resetn`  in  1: synchronous, active-low reset.
- `src_enable`  in  NUM_SRC: per-source arbitration enable (configuration).
- `src_tvalid`  in  NUM_SRC: per-source beat valid.
- `src_tready`  out  NUM_SRC: per-source beat accept.
- `src_tdata`  in  NUM_SRC*DATA_WIDTH: packed beat data; source i occupies slice i.
- `src_tid`  in  NUM_SRC*ID_WIDTH: packed tid.
- `src_tlast`  in  NUM_SRC: end of packet.
- `stream_tid`, `stream_tdest`, `stream_tdata`, `stream_tstrb`, `stream_tkeep`, `stream_tlast`, `stream_tuser`, `stream_tvalid`  out: AXI-Stream master, widths as in the parameters.
- `stream_tready`  in  1: downstream accept.
- `err_trunc`  out  1: sticky flag; a packet was truncated at MAX_BEATS.

## Operation
- States:
  - IDLE: no grant held.
  - BUSY: grant register `gnt` (index) is valid.
- IDLE:
  - Request vector is `src_tvalid & src_enable`.
  - If the vector is non-zero, pick the first requesting index searching upward from `last_gnt+1`, wrapping modulo NUM_SRC.
  - Register it in `gnt`, clear the beat counter, and go to BUSY.
  - All `src_tready` = 0 in IDLE.
- BUSY:
  - `src_tready[gnt] = !stream_tvalid || stream_tready`. Every other `src_tready` = 0.
  - A beat is accepted when `src_tvalid[gnt] && src_tready[gnt]`.
  - On an accepted beat, the output register loads:
    - `tdata` and `tid` from slice `gnt`;
    - `tdest` = `gnt`, zero-extended;
    - `tuser[15:0]` = packet sequence counter, upper bits 0;
    - `tkeep` = `tstrb` = all ones;
    - `tlast` = `src_tlast[gnt]` OR (beat counter == MAX_BEATS-1).
  - The beat counter increments on each accepted beat.
  - When the accepted beat's output `tlast` is 1:
    - `last_gnt` ← `gnt`;
    - sequence counter increments, wrapping at 2^16;
    - FSM returns to IDLE.
  - Truncation: if the forced tlast fires and `src_tlast` is 0, `err_trunc` ← 1. The rest of that source's packet is arbitrated later as a new packet.
- `src_enable` is sampled only in IDLE. Deasserting it in BUSY does not abort the current packet.
- Output register:
  - `stream_tvalid` clears on `stream_tready` when no new beat loads.
  - Load and drain in the same cycle is allowed (full throughput).

## Timing
- Reset values (`resetn` = 0 at a clock edge):
  - state = IDLE;
  - `last_gnt` = NUM_SRC-1, so source 0 wins first;
  - beat counter = 0, sequence counter = 0;
  - `err_trunc` = 0;
  - all `stream_*` outputs = 0, all `src_tready` = 0.
- Reset mid-packet: the buffered beat is discarded and no tlast is emitted; the source must restart.
- Latency:
  - Request to grant (IDLE→BUSY): 1 cycle.
  - Accept to `stream_tvalid`: 1 cycle.
  - First beat appears on the output 2 cycles after `src_tvalid` rises with no competition.
- Throughput: 1 beat/cycle within a packet. There is exactly one idle arbitration cycle between packets.
- Backpressure:
  - With `stream_tvalid` = 1 and `stream_tready` = 0, `src_tready[gnt]` = 0 and the output is held stable.
  - Output payload never changes while `stream_tvalid && !stream_tready`.
- If all requests drop while in IDLE, stay in IDLE. A source whose tvalid stalls mid-packet keeps the grant indefinitely; there is no timeout.
- Single requester: after each packet it is re-granted following the 1-cycle IDLE gap.

## Test plan
- Single packet: after reset, source 1 sends 3 beats with data 0xA1..0xA3 and tlast on beat 3, tready = 1. Required: output beats on cycles t+2..t+4, tdest = 1, tuser = 0, tlast only on the third beat.
- Round robin: all four sources each send one 2-beat packet continuously. Required grant order 0,1,2,3,0; tuser 0..4; no interleaving of beats between sources.
- Backpressure: hold `stream_tready` = 0 for 5 cycles mid-packet. Required: `src_tready` = 0 throughout, output payload stable, no beat lost or duplicated.
- Truncation: MAX_BEATS = 4, source 2 sends 6 beats with tlast on beat 6. Required:
  - output tlast on beat 4 and `err_trunc` = 1;
  - beats 5–6 delivered as a new packet with tdest = 2 and tuser incremented.
- Enable gating: `src_enable` = 4'b1010 with all sources valid. Only sources 1 and 3 are granted, alternating. Deasserting `src_enable[1]` mid-packet still completes that packet.
- Reset mid-packet: `resetn` = 0 for 1 cycle during beat 2 of 4. Required: all outputs 0 the next cycle, `err_trunc` = 0, and the next grant goes to source 0 if it is requesting.

Source files
------------

// File: rtl/snoop_stream_arbiter.sv
// snoop_stream_arbiter: packet-locked round-robin merge of the AR/R/AW/W snoop streams
// onto one AXI-Stream master, with a one-deep output register.
module snoop_stream_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 32,
    parameter int USER_WIDTH = 64,
    parameter int DEST_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int MAX_BEATS  = 256
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_SRC-1:0]            src_enable,
    input  logic [NUM_SRC-1:0]            src_tvalid,
    output logic [NUM_SRC-1:0]            src_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_SRC*ID_WIDTH-1:0]   src_tid,
    input  logic [NUM_SRC-1:0]            src_tlast,
    output logic [ID_WIDTH-1:0]           stream_tid,
    output logic [DEST_WIDTH-1:0]         stream_tdest,
    output logic [DATA_WIDTH-1:0]         stream_tdata,
    output logic [DATA_WIDTH/8-1:0]       stream_tstrb,
    output logic [DATA_WIDTH/8-1:0]       stream_tkeep,
    output logic                          stream_tlast,
    output logic [USER_WIDTH-1:0]         stream_tuser,
    output logic                          stream_tvalid,
    input  logic                          stream_tready,
    output logic                          err_trunc
);
    localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      gnt, last_gnt, pick, idx;
    logic [15:0]        beat_cnt, seq_cnt;
    logic [NUM_SRC-1:0] req;
    logic               out_ready, accept, force_last, beat_last;

    always_ff @(posedge clk)
        state <= !resetn ? IDLE : state_nxt;

    always_comb
        state_nxt = (state == IDLE) ? (|req ? BUSY : IDLE) : ((accept && beat_last) ? IDLE : BUSY);

    always_comb begin
        req        = src_tvalid & src_enable;
        out_ready  = !stream_tvalid || stream_tready;
        src_tready = (state == BUSY && out_ready) ? NUM_SRC'(1) << gnt : '0;
        accept     = state == BUSY && src_tvalid[gnt] && out_ready;
        force_last = beat_cnt == 16'(MAX_BEATS - 1);
        beat_last  = src_tlast[gnt] || force_last;
    end

    // Walk downward so the lowest offset from last_gnt+1 is the one that sticks.
    always_comb begin
        pick = last_gnt;
        idx  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx  = SW'((int'(last_gnt) + k) % NUM_SRC);
            pick = req[idx] ? idx : pick;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            gnt           <= '0;
            last_gnt      <= SW'(NUM_SRC - 1);
            beat_cnt      <= '0;
            seq_cnt       <= '0;
            err_trunc     <= 1'b0;
            stream_tvalid <= 1'b0;
            stream_tdata  <= '0;
            stream_tid    <= '0;
            stream_tdest  <= '0;
            stream_tuser  <= '0;
            stream_tkeep  <= '0;
            stream_tstrb  <= '0;
            stream_tlast  <= 1'b0;
        end else begin
            if (state == IDLE && |req) begin
                gnt      <= pick;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt     <= beat_cnt + 16'd1;
                stream_tdata <= src_tdata[gnt*DATA_WIDTH +: DATA_WIDTH];
                stream_tid   <= src_tid[gnt*ID_WIDTH +: ID_WIDTH];
                stream_tdest <= DEST_WIDTH'(gnt);
                stream_tuser <= USER_WIDTH'(seq_cnt);
                stream_tkeep <= '1;
                stream_tstrb <= '1;
                stream_tlast <= beat_last;
                if (beat_last) begin
                    last_gnt <= gnt;
                    seq_cnt  <= seq_cnt + 16'd1;
                end
                if (force_last && !src_tlast[gnt])
                    err_trunc <= 1'b1;
            end
            stream_tvalid <= accept || (stream_tvalid && !stream_tready);
        end
    end
endmodule

// File: tb/tb_snoop_stream_arbiter.sv
// tb_snoop_stream_arbiter: randomized sources checked against a packet-level
// round-robin reference model built from queued packets.
module tb_snoop_stream_arbiter;
    localparam int NS = 4, DW = 128, IW = 32, UW = 64, TW = 32, MAXB = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        int            dest;
        int            user;
        logic          last;
    } exp_t;

    logic              clk = 1'b0, resetn = 1'b0;
    logic [NS-1:0]     src_enable = '1, src_tvalid = '0, src_tlast = '0, src_tready;
    logic [NS*DW-1:0]  src_tdata = '0;
    logic [NS*IW-1:0]  src_tid = '0;
    logic [IW-1:0]     stream_tid;
    logic [TW-1:0]     stream_tdest;
    logic [DW-1:0]     stream_tdata;
    logic [DW/8-1:0]   stream_tstrb, stream_tkeep;
    logic              stream_tlast, stream_tvalid, err_trunc;
    logic [UW-1:0]     stream_tuser;
    logic              stream_tready = 1'b0;

    always #5 clk = ~clk;

    snoop_stream_arbiter #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .DEST_WIDTH(TW),
        .NUM_SRC(NS), .MAX_BEATS(MAXB)
    ) dut (
        .clk(clk), .resetn(resetn), .src_enable(src_enable), .src_tvalid(src_tvalid),
        .src_tready(src_tready), .src_tdata(src_tdata), .src_tid(src_tid), .src_tlast(src_tlast),
        .stream_tid(stream_tid), .stream_tdest(stream_tdest), .stream_tdata(stream_tdata),
        .stream_tstrb(stream_tstrb), .stream_tkeep(stream_tkeep), .stream_tlast(stream_tlast),
        .stream_tuser(stream_tuser), .stream_tvalid(stream_tvalid), .stream_tready(stream_tready),
        .err_trunc(err_trunc)
    );

    beat_t src_q[NS][$];
    exp_t  exp_q[$];
    int    out_cyc[$], last_dest[$];
    int    pos[NS];
    int    m_last = NS - 1, m_seq = 0;
    logic  m_err = 1'b0;
    int    n_chk = 0, n_fail = 0;

    task automatic add_pkt(input int s, input int len, input int base);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b.data = (base != 0) ? DW'(base + k) : {$urandom, $urandom, $urandom, $urandom};
            b.id   = $urandom;
            b.last = (k == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    // Packet-level model: each IDLE picks the next enabled source with data after
    // the last winner; a packet ends at its tlast or after MAXB beats.
    task automatic build_expected(input logic [NS-1:0] en);
        beat_t q[NS][$];
        beat_t b;
        exp_t  e;
        int    s, n;
        logic  l;
        for (int i = 0; i < NS; i++) q[i] = src_q[i];
        while (1) begin
            s = -1;
            for (int k = 1; k <= NS; k++)
                if (s < 0 && en[(m_last + k) % NS] && q[(m_last + k) % NS].size() > 0) s = (m_last + k) % NS;
            if (s < 0) break;
            n = 0;
            while (q[s].size() > 0) begin
                b = q[s].pop_front();
                n++;
                l = b.last || n == MAXB;
                if (l && !b.last) m_err = 1'b1;
                e.data = b.data; e.id = b.id; e.dest = s; e.user = m_seq; e.last = l;
                exp_q.push_back(e);
                if (l) break;
            end
            m_seq  = (m_seq + 1) % 65536;
            m_last = s;
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            pos[i] = 0;
        end
        src_tvalid = '0;
        src_tlast  = '0;
        src_enable = '1;
    endtask

    task automatic idle_cycles(input int n);
        clear_srcs();
        stream_tready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_srcs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        m_last = NS - 1;
        m_seq  = 0;
        m_err  = 1'b0;
    endtask

    // Drives the queued packets and checks every delivered beat against exp_q.
    task automatic run_stream(input int stall_pct, input int bp_pct, input int bp_lo, input int bp_hi,
                              input int en_cyc, input logic [NS-1:0] en_val);
        logic [NS-1:0] acc = '0;
        logic          prev_hold = 1'b0, hold_i;
        logic [288:0]  pay, prev_pay = '0, want;
        exp_t          e;
        beat_t         b;
        int            cyc = 0;
        out_cyc.delete();
        last_dest.delete();
        while (exp_q.size() > 0 && cyc < 2000) begin
            if (cyc == en_cyc) src_enable = en_val;
            stream_tready = !(cyc >= bp_lo && cyc < bp_hi) && ($urandom_range(99) >= bp_pct);
            for (int i = 0; i < NS; i++) begin
                hold_i = src_tvalid[i] && !acc[i];
                src_tvalid[i] = src_q[i].size() > 0 && (hold_i || pos[i] == 0 || $urandom_range(99) >= stall_pct);
                if (src_q[i].size() > 0) begin
                    src_tdata[i*DW +: DW] = src_q[i][0].data;
                    src_tid[i*IW +: IW]   = src_q[i][0].id;
                    src_tlast[i]          = src_q[i][0].last;
                end
            end
            @(negedge clk);
            pay = {stream_tdata, stream_tid, stream_tdest, stream_tuser, stream_tlast, stream_tkeep, stream_tstrb};
            if (prev_hold) begin
                n_chk++;
                if (!stream_tvalid || pay !== prev_pay) begin
                    n_fail++;
                    $display("FAIL hold_stable cyc %0d: got valid=%0b dest=%0d user=%0d data=%h, required valid=1 data=%h",
                             cyc, stream_tvalid, stream_tdest, stream_tuser, stream_tdata, prev_pay[288:161]);
                end
            end
            if (stream_tvalid && !stream_tready) begin
                n_chk++;
                if (src_tready !== '0) begin
                    n_fail++;
                    $display("FAIL bp_src_tready cyc %0d: got %b, required 0000", cyc, src_tready);
                end
            end
            if (stream_tvalid && stream_tready) begin
                e = exp_q.pop_front();
                want = {e.data, e.id, TW'(e.dest), UW'(e.user), e.last, 16'hffff, 16'hffff};
                n_chk++;
                if (pay !== want) begin
                    n_fail++;
                    $display("FAIL beat cyc %0d: got dest=%0d user=%0d last=%0b id=%h data=%h, required dest=%0d user=%0d last=%0b id=%h data=%h",
                             cyc, stream_tdest, stream_tuser, stream_tlast, stream_tid, stream_tdata,
                             e.dest, e.user, e.last, e.id, e.data);
                end
                out_cyc.push_back(cyc);
                if (stream_tlast) last_dest.push_back(int'(stream_tdest));
            end
            prev_hold = stream_tvalid && !stream_tready;
            prev_pay  = pay;
            acc       = src_tvalid & src_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++)
                if (acc[i]) begin
                    b = src_q[i].pop_front();
                    pos[i] = (b.last || pos[i] + 1 == MAXB) ? 0 : pos[i] + 1;
                end
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL stream_timeout: got %0d beats undelivered, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_chk++;
        if ({stream_tvalid, stream_tdata, stream_tid, stream_tdest, stream_tuser, stream_tlast,
             stream_tkeep, stream_tstrb, src_tready, err_trunc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b dest=%0d user=%0d keep=%h tready=%b err=%0b, required all 0",
                     stream_tvalid, stream_tdest, stream_tuser, stream_tkeep, src_tready, err_trunc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_packet();
        int got;
        do_reset();
        add_pkt(1, 3, 'hA1);
        build_expected('1);
        run_stream(0, 0, -1, -1, -1, '1);
        for (int k = 0; k < 3; k++) begin
            got = k < out_cyc.size() ? out_cyc[k] : -1;
            n_chk++;
            if (got != k + 2) begin
                n_fail++;
                $display("FAIL single_latency[%0d]: got cycle %0d, required %0d", k, got, k + 2);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_round_robin();
        int want_d[5] = '{0, 1, 2, 3, 0};
        int got;
        do_reset();
        for (int s = 0; s < NS; s++) add_pkt(s, 2, 0);
        add_pkt(0, 2, 0);
        build_expected('1);
        run_stream(0, 0, -1, -1, -1, '1);
        for (int k = 0; k < 5; k++) begin
            got = k < last_dest.size() ? last_dest[k] : -1;
            n_chk++;
            if (got != want_d[k]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got src %0d, required %0d", k, got, want_d[k]);
            end
        end
        // Two beats back-to-back, then one arbitration cycle before the next packet.
        for (int k = 0; k < 10; k++) begin
            got = k < out_cyc.size() ? out_cyc[k] : -1;
            n_chk++;
            if (got != 2 + 3 * (k / 2) + k % 2) begin
                n_fail++;
                $display("FAIL rr_timing[%0d]: got cycle %0d, required %0d", k, got, 2 + 3 * (k / 2) + k % 2);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_backpressure();
        add_pkt(0, 4, 0);
        add_pkt(3, 3, 0);
        build_expected('1);
        run_stream(0, 0, 3, 8, -1, '1);
        n_chk++;
        if (out_cyc.size() != 7) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats, required 7", out_cyc.size());
        end
        idle_cycles(2);
    endtask

    task automatic test_truncation();
        n_chk++;
        if (err_trunc !== 1'b0) begin
            n_fail++;
            $display("FAIL trunc_pre: got err_trunc=%0b, required 0", err_trunc);
        end
        add_pkt(2, 6, 0);
        build_expected('1);
        run_stream(0, 0, -1, -1, -1, '1);
        n_chk++;
        if (err_trunc !== 1'b1) begin
            n_fail++;
            $display("FAIL trunc_flag: got err_trunc=%0b, required 1", err_trunc);
        end
        n_chk++;
        if (last_dest.size() != 2 || out_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL trunc_split: got %0d packets %0d beats, required 2 packets 6 beats", last_dest.size(), out_cyc.size());
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_packet();
        n_chk++;
        if (err_trunc !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_err: got err_trunc=%0b, required 1", err_trunc);
        end
        stream_tready = 1'b1;
        src_tvalid[1] = 1'b1;
        src_tdata[1*DW +: DW] = DW'('hB1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        src_tdata[1*DW +: DW] = DW'('hB2);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        src_tvalid[0] = 1'b1;
        src_tlast[0]  = 1'b1;
        src_tdata[0*DW +: DW] = DW'('h5A);
        @(negedge clk);
        n_chk++;
        if ({stream_tvalid, stream_tdata, stream_tid, stream_tdest, stream_tuser, stream_tlast,
             stream_tkeep, stream_tstrb, src_tready, err_trunc} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got valid=%0b data=%h last=%0b tready=%b err=%0b, required all 0",
                     stream_tvalid, stream_tdata, stream_tlast, src_tready, err_trunc);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (!stream_tvalid || stream_tdest !== 0 || stream_tuser !== 0 || !stream_tlast || stream_tdata !== DW'('h5A)) begin
            n_fail++;
            $display("FAIL rst_regrant: got valid=%0b dest=%0d user=%0d last=%0b data=%h, required valid=1 dest=0 user=0 last=1 data=5a",
                     stream_tvalid, stream_tdest, stream_tuser, stream_tlast, stream_tdata);
        end
        src_tvalid = '0;
        m_last = 0;
        m_seq  = 1;
        m_err  = 1'b0;
        @(posedge clk);
        #1;
        idle_cycles(2);
    endtask

    task automatic test_enable_gating();
        int want_d[4] = '{1, 3, 1, 3};
        int got;
        do_reset();
        for (int s = 0; s < NS; s++) begin
            add_pkt(s, 2, 0);
            add_pkt(s, 2, 0);
        end
        src_enable = 4'b1010;
        build_expected(4'b1010);
        run_stream(0, 0, -1, -1, -1, 4'b1010);
        for (int k = 0; k < 4; k++) begin
            got = k < last_dest.size() ? last_dest[k] : -1;
            n_chk++;
            if (got != want_d[k]) begin
                n_fail++;
                $display("FAIL en_order[%0d]: got src %0d, required %0d", k, got, want_d[k]);
            end
        end
        idle_cycles(2);
        do_reset();
        add_pkt(1, 4, 0);
        add_pkt(3, 2, 0);
        add_pkt(0, 2, 0);
        add_pkt(2, 2, 0);
        src_enable = 4'b1010;
        build_expected(4'b1010);
        run_stream(0, 0, -1, -1, 2, 4'b1000);
        n_chk++;
        if (last_dest.size() != 2 || out_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL en_drop_mid: got %0d packets %0d beats, required 2 packets 6 beats", last_dest.size(), out_cyc.size());
        end
        idle_cycles(2);
    endtask

    task automatic test_random();
        logic [NS-1:0] en;
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < NS; s++)
                repeat ($urandom_range(3)) add_pkt(s, $urandom_range(1, 7), 0);
            en = NS'($urandom_range(1, 15));
            src_enable = en;
            build_expected(en);
            run_stream(30, 30, -1, -1, -1, en);
            idle_cycles(3);
            n_chk++;
            if (err_trunc !== m_err) begin
                n_fail++;
                $display("FAIL rand_err_trunc round %0d: got %0b, required %0b", r, err_trunc, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_reset_mid_packet();
        test_enable_gating();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before time 500000");
        $fatal(1, "watchdog");
    end
endmodule
